msg_scheduler: RTL and testbench
================================

MSG_SCHEDULER -- requirements
Module: msg_scheduler

Interface
REQ-001 Parameter LEN0, default 11, character count of message 0 (legal 1..16).
REQ-002 Parameter LEN1, default 10, character count of message 1 (legal 1..16).
REQ-003 Parameter LEN2, default 7, character count of message 2 (legal 1..16).
REQ-004 Parameter LEN3, default 4, character count of message 3 (legal 1..16).
REQ-005 Parameter GAP, default 16, idle cycles between messages (legal 0..255).
REQ-006 sysclk  in  1  single clock; all state on rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 req  in  4  per-message request, one-cycle pulse per bit (already debounced).
REQ-009 auto_en  in  1  level; high = cycle messages continuously.
REQ-010 rom_sel  out  2  message index presented to the character store.
REQ-011 rom_addr  out  4  character index presented to the character store.
REQ-012 rom_data  in  8  character from store, valid the cycle after rom_sel/rom_addr change.
REQ-013 tx_data  out  8  byte to serial transmitter.
REQ-014 tx_start  out  1  transmit request, held until accepted.
REQ-015 tx_busy  in  1  transmitter busy; high = byte accepted/in flight.
REQ-016 busy  out  1  high while any state other than IDLE.
REQ-017 done  out  1  one-cycle pulse after last character of a message is drained.
REQ-018 cur_msg  out  2  index of message in progress (last granted when idle).

Function
REQ-019 Each req bit SHALL set a sticky pending[i] flag; pending[i] SHALL clear in the cycle message i is granted.
REQ-020 A req[i] pulse during transmission of message i SHALL re-set pending[i], queuing a repeat.
REQ-021 Grant in IDLE: round-robin over pending, search starting at (last+1) mod 4, last = most recently granted index (3 after reset).
REQ-022 In IDLE with no pending and auto_en=1, SHALL grant (last+1) mod 4; pending requests take priority over auto.
REQ-023 States: IDLE, FETCH, SEND, DRAIN, GAP; FSM SHALL be one-hot or binary, implementer's choice.
REQ-024 IDLE->FETCH on grant: rom_sel<=granted index, rom_addr<=0, cur_msg<=index, last<=index.
REQ-025 FETCH lasts exactly one cycle; on exit tx_data<=rom_data; next SEND.
REQ-026 SEND: tx_start=1; stay until tx_busy=1 sampled, then DRAIN (tx_start low from that cycle on).
REQ-027 DRAIN: wait for tx_busy=0; then if rom_addr==LEN(sel)-1 -> GAP with done pulse, else rom_addr+1 -> FETCH.
REQ-028 rom_addr SHALL never exceed LEN(sel)-1; no wrap to 0 within a message.
REQ-029 GAP: count GAP cycles (8-bit counter), then IDLE; GAP=0 goes IDLE the next cycle.
REQ-030 tx_data SHALL be stable for the whole SEND state.
REQ-031 auto_en falling mid-message SHALL NOT abort; message completes, then IDLE unless pending.
REQ-032 Simultaneous req bits in one cycle SHALL all register; grant order per REQ-021.
REQ-033 tx_busy already high on SEND entry counts as acceptance (DRAIN next cycle).
REQ-034 Latency: grant cycle to first tx_start high = 2 cycles.

Reset
REQ-035 rst_n low SHALL immediately force IDLE, pending=0, last=3, rom_sel=0, rom_addr=0, tx_data=0, tx_start=0, busy=0, done=0, cur_msg=0, gap counter=0.
REQ-036 Reset mid-message SHALL drop the message; no resume after release.
REQ-037 First grant possible on the first rising edge after rst_n deasserts.

Verification
REQ-038 req=0001 pulse, transmitter model busy 5 cycles per byte -> 11 tx_start handshakes, rom_sel=0, rom_addr 0..10, one done pulse, busy high throughout.
REQ-039 req=1010 same cycle after reset -> message 1 sent fully, then GAP 16 cycles, then message 3; pending=0 at end.
REQ-040 auto_en=1, no req -> message order 0,1,2,3,0; after req[2] pulse during message 0, next message is 2 not 1.
REQ-041 auto_en dropped during 3rd character of message 2 -> all 7 characters sent, done pulse, then IDLE (busy=0).
REQ-042 rst_n low during DRAIN of message 1 -> tx_start=0 and busy=0 asynchronously; after release with no req, stays IDLE.
REQ-043 tx_busy held high at SEND entry -> DRAIN entered next cycle; tx_start high exactly one cycle.

Source files
------------

// File: rtl/msg_scheduler.sv
// Round-robin message scheduler: picks a pending (or auto-cycled) message and
// streams its characters from an external store to a byte-wide serial transmitter.
module msg_scheduler #(
    parameter int unsigned LEN0 = 11,
    parameter int unsigned LEN1 = 10,
    parameter int unsigned LEN2 = 7,
    parameter int unsigned LEN3 = 4,
    parameter int unsigned GAP  = 16
) (
    input  logic       sysclk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       auto_en,
    output logic [1:0] rom_sel,
    output logic [3:0] rom_addr,
    input  logic [7:0] rom_data,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_busy,
    output logic       busy,
    output logic       done,
    output logic [1:0] cur_msg
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_SEND  = 3'd2,
        S_DRAIN = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    localparam logic [7:0] GAP_LAST = (GAP == 0) ? 8'd0 : 8'(GAP - 1);

    state_t     state;
    logic [3:0] pending;
    logic [1:0] last;
    logic [7:0] gap_cnt;

    logic [3:0] req_all_c;
    logic [1:0] grant_idx_c;
    logic [1:0] cand_c;
    logic       found_c;
    logic       grant_vld_c;

    function automatic logic [3:0] last_addr(input logic [1:0] sel);
        case (sel)
            2'd0:    return 4'(LEN0 - 1);
            2'd1:    return 4'(LEN1 - 1);
            2'd2:    return 4'(LEN2 - 1);
            default: return 4'(LEN3 - 1);
        endcase
    endfunction

    // Round-robin search from last+1; a same-cycle req is visible to the grant.
    always_comb begin
        req_all_c   = pending | req;
        found_c     = 1'b0;
        cand_c      = 2'd0;
        grant_idx_c = 2'(last + 2'd1);
        for (int k = 1; k <= 4; k++) begin
            cand_c = 2'(last + 2'(k));
            if (!found_c && req_all_c[cand_c]) begin
                found_c     = 1'b1;
                grant_idx_c = cand_c;
            end
        end
        grant_vld_c = found_c | auto_en;
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            pending  <= 4'd0;
            last     <= 2'd3;
            rom_sel  <= 2'd0;
            rom_addr <= 4'd0;
            tx_data  <= 8'd0;
            tx_start <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            cur_msg  <= 2'd0;
            gap_cnt  <= 8'd0;
        end else begin
            done    <= 1'b0;
            pending <= pending | req;
            case (state)
                S_IDLE: begin
                    if (grant_vld_c) begin
                        state    <= S_FETCH;
                        rom_sel  <= grant_idx_c;
                        rom_addr <= 4'd0;
                        cur_msg  <= grant_idx_c;
                        last     <= grant_idx_c;
                        busy     <= 1'b1;
                        pending  <= req_all_c & ~(4'b0001 << grant_idx_c);
                    end
                end
                S_FETCH: begin
                    tx_data  <= rom_data;
                    tx_start <= 1'b1;
                    state    <= S_SEND;
                end
                S_SEND: begin
                    if (tx_busy) begin
                        tx_start <= 1'b0;
                        state    <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!tx_busy) begin
                        if (rom_addr == last_addr(rom_sel)) begin
                            done    <= 1'b1;
                            gap_cnt <= 8'd0;
                            state   <= S_GAP;
                        end else begin
                            rom_addr <= rom_addr + 4'd1;
                            state    <= S_FETCH;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    tx_start <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_msg_scheduler.sv
// Scoreboard bench for msg_scheduler: expected characters/done pulses are queued
// from a round-robin reference model and popped by a monitor on each handshake.
module tb_msg_scheduler;

    localparam int unsigned LEN0 = 11;
    localparam int unsigned LEN1 = 10;
    localparam int unsigned LEN2 = 7;
    localparam int unsigned LEN3 = 4;
    localparam int unsigned GAP  = 16;

    logic       sysclk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       auto_en;
    logic [1:0] rom_sel;
    logic [3:0] rom_addr;
    logic [7:0] rom_data;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic       busy;
    logic       done;
    logic [1:0] cur_msg;

    always #5 sysclk = ~sysclk;

    msg_scheduler #(
        .LEN0(LEN0), .LEN1(LEN1), .LEN2(LEN2), .LEN3(LEN3), .GAP(GAP)
    ) dut (
        .sysclk  (sysclk),
        .rst_n   (rst_n),
        .req     (req),
        .auto_en (auto_en),
        .rom_sel (rom_sel),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .tx_data (tx_data),
        .tx_start(tx_start),
        .tx_busy (tx_busy),
        .busy    (busy),
        .done    (done),
        .cur_msg (cur_msg)
    );

    typedef struct {
        logic [1:0] msg;
        logic [3:0] addr;
        logic [7:0] ch;
    } exp_t;

    exp_t       hs_q[$];
    logic [1:0] done_q[$];

    int checks = 0;
    int errors = 0;
    int hs_count = 0;
    int done_cnt = 0;

    function automatic int msg_len(input int m);
        case (m)
            0:       return int'(LEN0);
            1:       return int'(LEN1);
            2:       return int'(LEN2);
            default: return int'(LEN3);
        endcase
    endfunction

    function automatic logic [7:0] char_of(input logic [1:0] s, input logic [3:0] a);
        logic [7:0] v;
        v = {2'b00, s, a};
        return v ^ 8'hA5;
    endfunction

    task automatic check(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    // Character store: combinational lookup of the presented index.
    assign rom_data = char_of(rom_sel, rom_addr);

    // Transmitter model: accepts a byte when idle, then stays busy a few cycles.
    int   busy_cnt;
    logic rand_busy;
    logic force_busy;
    assign tx_busy = (busy_cnt != 0) || force_busy;

    always @(posedge sysclk or negedge rst_n) begin
        if (!rst_n)
            busy_cnt <= 0;
        else if (busy_cnt > 0)
            busy_cnt <= busy_cnt - 1;
        else if (tx_start)
            busy_cnt <= rand_busy ? int'($urandom_range(6, 1)) : 5;
    end

    // Monitor: a handshake is the SEND cycle in which the DUT sees tx_busy high.
    logic       prev_busy;
    logic       prev_tx_start;
    logic [7:0] prev_tx_data;
    logic       lat_pend;
    exp_t       e;
    logic [1:0] dm;

    always @(negedge sysclk) begin
        if (!rst_n) begin
            prev_busy     = 1'b0;
            prev_tx_start = 1'b0;
            lat_pend      = 1'b0;
        end else begin
            if (tx_start && tx_busy) begin
                hs_count++;
                if (hs_q.size() == 0) begin
                    check("unexpected_handshake", hs_q.size(), 1);
                end else begin
                    e = hs_q.pop_front();
                    check("hs_rom_sel", int'(rom_sel), int'(e.msg));
                    check("hs_rom_addr", int'(rom_addr), int'(e.addr));
                    check("hs_tx_data", int'(tx_data), int'(e.ch));
                    check("hs_cur_msg", int'(cur_msg), int'(e.msg));
                    check("hs_busy", int'(busy), 1);
                end
            end
            if (tx_start && prev_tx_start)
                check("tx_data_stable", int'(tx_data), int'(prev_tx_data));
            if (lat_pend) begin
                check("grant_latency", int'(tx_start), 1);
                lat_pend = 1'b0;
            end
            if (busy && !prev_busy)
                lat_pend = 1'b1;
            if (done) begin
                done_cnt++;
                if (done_q.size() == 0) begin
                    check("unexpected_done", done_q.size(), 1);
                end else begin
                    dm = done_q.pop_front();
                    check("done_msg", int'(cur_msg), int'(dm));
                    check("done_addr", int'(rom_addr), msg_len(int'(cur_msg)) - 1);
                end
            end
            prev_busy     = busy;
            prev_tx_start = tx_start;
            prev_tx_data  = tx_data;
        end
    end

    int model_last;

    task automatic push_msg(input int m);
        exp_t x;
        for (int a = 0; a < msg_len(m); a++) begin
            x.msg  = 2'(m);
            x.addr = 4'(a);
            x.ch   = char_of(2'(m), 4'(a));
            hs_q.push_back(x);
        end
        done_q.push_back(2'(m));
    endtask

    task automatic pulse_req(input logic [3:0] m);
        @(posedge sysclk);
        #1 req = m;
        @(posedge sysclk);
        #1 req = 4'd0;
    endtask

    task automatic wait_idle(input int target);
        int n;
        n = 0;
        while ((done_cnt < target || busy) && n < 20000) begin
            @(negedge sysclk);
            n++;
        end
        check("idle_reached", int'(n < 20000), 1);
        check("idle_busy", int'(busy), 0);
    endtask

    task automatic wait_hs(input int target);
        int n;
        n = 0;
        while (hs_count < target && n < 20000) begin
            @(negedge sysclk);
            n++;
        end
        check("hs_reached", int'(n < 20000), 1);
    endtask

    task automatic do_reset(input bit chk);
        rst_n   = 1'b0;
        req     = 4'd0;
        auto_en = 1'b0;
        repeat (3) @(posedge sysclk);
        #1;
        if (chk) begin
            check("rst_busy", int'(busy), 0);
            check("rst_done", int'(done), 0);
            check("rst_tx_start", int'(tx_start), 0);
            check("rst_rom_sel", int'(rom_sel), 0);
            check("rst_rom_addr", int'(rom_addr), 0);
            check("rst_tx_data", int'(tx_data), 0);
            check("rst_cur_msg", int'(cur_msg), 0);
        end
        hs_q.delete();
        done_q.delete();
        model_last = 3;
    endtask

    int          d0;
    int          h0;
    int          n;
    int          idx;
    int          cnt;
    bit          first;
    logic [3:0]  pend;
    logic [3:0]  mask;
    logic [3:0]  extra;

    initial begin
        rst_n      = 1'b0;
        req        = 4'd0;
        auto_en    = 1'b0;
        rand_busy  = 1'b0;
        force_busy = 1'b0;

        // Single request, fixed 5-cycle transmitter.
        do_reset(1);
        @(posedge sysclk);
        #1 rst_n = 1'b1;
        d0 = done_cnt; h0 = hs_count;
        push_msg(0); model_last = 0;
        pulse_req(4'b0001);
        wait_idle(d0 + 1);
        check("msg0_handshakes", hs_count - h0, 11);
        check("msg0_done_count", done_cnt - d0, 1);

        // Two simultaneous requests on the first edge after reset release.
        do_reset(0);
        push_msg(1); push_msg(3); model_last = 3;
        d0 = done_cnt; h0 = hs_count;
        @(posedge sysclk);
        #1 rst_n = 1'b1;
        req = 4'b1010;
        @(posedge sysclk);
        #1 req = 4'd0;
        check("first_edge_grant", int'(busy), 1);
        n = 0;
        while (!done && n < 2000) begin @(negedge sysclk); n++; end
        n = 0;
        while (!tx_start && n < 200) begin @(negedge sysclk); n++; end
        check("gap_min", int'(n >= int'(GAP)), 1);
        check("gap_max", int'(n <= int'(GAP) + 3), 1);
        wait_idle(d0 + 2);
        check("pair_handshakes", hs_count - h0, int'(LEN1 + LEN3));

        // Randomised request sets with an optional re-request during the first message.
        rand_busy = 1'b1;
        for (int r = 0; r < 6; r++) begin
            mask  = 4'($urandom_range(15, 1));
            extra = 4'($urandom_range(15, 0));
            pend  = mask;
            first = 1'b1;
            cnt   = 0;
            while (pend != 4'd0) begin
                idx = 0;
                for (int k = 1; k <= 4; k++) begin
                    idx = (model_last + k) % 4;
                    if (pend[idx]) break;
                end
                pend[idx]  = 1'b0;
                model_last = idx;
                push_msg(idx);
                cnt++;
                if (first) begin
                    pend  = pend | extra;
                    first = 1'b0;
                end
            end
            d0 = done_cnt; h0 = hs_count;
            pulse_req(mask);
            wait_hs(h0 + 1);
            if (extra != 4'd0) pulse_req(extra);
            wait_idle(d0 + cnt);
        end

        // Auto cycling, pending priority, and auto_en dropped mid-message.
        do_reset(0);
        push_msg(0); push_msg(1); push_msg(2); push_msg(3); push_msg(0); push_msg(2);
        d0 = done_cnt; h0 = hs_count;
        @(posedge sysclk);
        #1 rst_n = 1'b1;
        auto_en = 1'b1;
        wait_hs(h0 + int'(LEN0 + LEN1 + LEN2 + LEN3) + 1);
        pulse_req(4'b0100);
        wait_hs(h0 + int'(2 * LEN0 + LEN1 + LEN2 + LEN3) + 2);
        auto_en = 1'b0;
        wait_idle(d0 + 6);
        repeat (40) @(negedge sysclk);
        check("auto_stopped_busy", int'(busy), 0);
        check("auto_handshakes", hs_count - h0, int'(2 * LEN0 + LEN1 + 2 * LEN2 + LEN3));
        model_last = 2;

        // Reset asserted while draining a character of message 1.
        push_msg(1);
        h0 = hs_count;
        pulse_req(4'b0010);
        wait_hs(h0 + 2);
        n = 0;
        while (!(busy && !tx_start && tx_busy) && n < 200) begin @(negedge sysclk); n++; end
        check("drain_found", int'(n < 200), 1);
        #1 rst_n = 1'b0;
        #1;
        check("async_tx_start", int'(tx_start), 0);
        check("async_busy", int'(busy), 0);
        hs_q.delete();
        done_q.delete();
        model_last = 3;
        h0 = hs_count;
        @(posedge sysclk);
        #1 rst_n = 1'b1;
        repeat (40) @(negedge sysclk);
        check("no_resume_busy", int'(busy), 0);
        check("no_resume_hs", hs_count - h0, 0);

        // Transmitter already busy when SEND is entered.
        force_busy = 1'b1;
        push_msg(2); model_last = 2;
        d0 = done_cnt;
        pulse_req(4'b0100);
        n = 0;
        while (!tx_start && n < 20) begin @(negedge sysclk); n++; end
        n = 0;
        while (tx_start && n < 10) begin n++; @(negedge sysclk); end
        check("tx_start_width", n, 1);
        force_busy = 1'b0;
        wait_idle(d0 + 1);

        check("hs_queue_empty", hs_q.size(), 0);
        check("done_queue_empty", done_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
